// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - control/status bundle for clk_div_prog (sync_in present with CLKDIV_SYNC_EN)
interface clk_div_prog_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
`ifdef CLKDIV_SYNC_EN
  logic             sync_in;
`endif
  logic             div_ack;
  logic             err_div;
  logic [CNT_W-1:0] div_cur;
  logic             clk_out;
  logic             tick;

  // Requester side: drives enable and divisor loads, observes status.
  modport master (
    output en, div_in, div_load,
`ifdef CLKDIV_SYNC_EN
    output sync_in,
`endif
    input  div_ack, err_div, div_cur, clk_out, tick
  );

  // Divider side.
  modport slave (
    input  en, div_in, div_load,
`ifdef CLKDIV_SYNC_EN
    input  sync_in,
`endif
    output div_ack, err_div, div_cur, clk_out, tick
  );
endinterface

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable glitch-free clock divider; optional CLKDIV_SYNC_EN adds sync_in
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 54,
  parameter int DIV_MIN     = 2
) (
  input  logic            clk27m_i,
  input  logic            rst_i,
  clk_div_prog_if.slave   ctl_io
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             force_bnd;
  logic             apply;
  logic             load_ok;
  logic [CNT_W-1:0] low_len;

  // Forced period boundary from the external sync pulse (only while counting).
`ifdef CLKDIV_SYNC_EN
  assign force_bnd = ctl_io.en & ctl_io.sync_in;
`else
  assign force_bnd = 1'b0;
`endif

  // Next-state: counter, divisor hand-over and registered outputs derived from cnt_d.
  always_comb begin
    wrap    = ctl_io.en && (cnt_q == div_cur_q - CNT_W'(1));
    // A pending divisor lands only at a period boundary, or immediately when stopped.
    apply   = pend_valid_q && (!ctl_io.en || wrap || force_bnd);
    load_ok = ctl_io.div_load && (ctl_io.div_in >= CNT_W'(DIV_MIN));
    err_d   = ctl_io.div_load && (ctl_io.div_in < CNT_W'(DIV_MIN));
    ack_d   = apply;

    div_cur_d    = apply ? pend_q : div_cur_q;
    pend_d       = load_ok ? ctl_io.div_in : pend_q;
    // A load arriving on the apply edge becomes the next pending value.
    pend_valid_d = load_ok || (pend_valid_q && !apply);

    if (!ctl_io.en) begin
      cnt_d = apply ? '0 : cnt_q;
    end else if (wrap || force_bnd) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Low phase is the ceiling half, so odd divisors spend the extra cycle low.
    low_len   = div_cur_d - (div_cur_d >> 1);
    clk_out_d = (cnt_d >= low_len);
    tick_d    = ctl_io.en && (cnt_d == div_cur_d - CNT_W'(1));
  end

  // State register; reset restarts the period and drops any pending divisor.
  always_ff @(posedge clk27m_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      div_cur_q    <= CNT_W'(DIV_DEFAULT);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_cur_q    <= div_cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign ctl_io.div_ack = ack_q;
  assign ctl_io.err_div = err_q;
  assign ctl_io.div_cur = div_cur_q;
  assign ctl_io.clk_out = clk_out_q;
  assign ctl_io.tick    = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed table-driven bench for clk_div_prog
module tb_clk_div_prog;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  clk_div_prog_if #(.CNT_W(16)) ctl_io ();

  clk_div_prog #(.CNT_W(16), .DIV_DEFAULT(54), .DIV_MIN(2)) dut (
    .clk27m_i (clk),
    .rst_i    (rst),
    .ctl_io   (ctl_io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int div_in;
    int load_at;
    int wait_n;
    int lo;
    int hi;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int v);
    ctl_io.div_load = 1'b1;
    ctl_io.div_in   = 16'(v);
    step();
    ctl_io.div_load = 1'b0;
  endtask

  // Called at the first cycle of a period; runs exactly one period.
  task automatic measure(input string name, input int lo, input int hi);
    int low_n, high_n, tick_n, tick_last, order_bad, acks, d;
    low_n = 0; high_n = 0; tick_n = 0; tick_last = 0; order_bad = 0; acks = 0;
    d = lo + hi;
    for (int i = 0; i < d; i++) begin
      if (ctl_io.clk_out) high_n++;
      else begin
        low_n++;
        if (high_n > 0) order_bad++;
      end
      if (ctl_io.tick) begin
        tick_n++;
        if (i == d - 1) tick_last = 1;
      end
      if (i > 0 && ctl_io.div_ack) acks++;
      step();
    end
    check({name, "_low"}, low_n, lo);
    check({name, "_high"}, high_n, hi);
    check({name, "_ticks"}, tick_n, 1);
    check({name, "_tick_last"}, tick_last, 1);
    check({name, "_order"}, order_bad, 0);
    check({name, "_acks"}, acks, 0);
  endtask

  task automatic wait_ack(input string name, input int exp_wait, input int exp_div);
    int n;
    n = 0;
    while (!ctl_io.div_ack && n < exp_wait + 10) begin
      step();
      n++;
    end
    check({name, "_ack_wait"}, n, exp_wait);
    check({name, "_div_cur"}, int'(ctl_io.div_cur), exp_div);
  endtask

  initial begin
    int n, hold_bad, acks, prev_div;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    ctl_io.en       = 1'b1;
    ctl_io.div_in   = '0;
    ctl_io.div_load = 1'b0;
`ifdef CLKDIV_SYNC_EN
    ctl_io.sync_in  = 1'b0;
`endif

    tbl[0] = '{div_in: 2,  load_at: 0, wait_n: 4,  lo: 1,  hi: 1};
    tbl[1] = '{div_in: 7,  load_at: 1, wait_n: 2,  lo: 4,  hi: 3};
    tbl[2] = '{div_in: 3,  load_at: 3, wait_n: 3,  lo: 2,  hi: 1};
    tbl[3] = '{div_in: 16, load_at: 2, wait_n: 3,  lo: 8,  hi: 8};
    tbl[4] = '{div_in: 54, load_at: 5, wait_n: 10, lo: 27, hi: 27};

    // Reset state
    repeat (3) step();
    check("rst_clk_out", int'(ctl_io.clk_out), 0);
    check("rst_tick", int'(ctl_io.tick), 0);
    check("rst_div_cur", int'(ctl_io.div_cur), 54);
    check("rst_ack", int'(ctl_io.div_ack), 0);
    check("rst_err", int'(ctl_io.err_div), 0);
    rst = 1'b0;

    // Default ratio
    measure("d54_p0", 27, 27);
    measure("d54_p1", 27, 27);

    // Load 5 at cnt=10
    repeat (10) step();
    load(5);
    check("ld5_div_hold", int'(ctl_io.div_cur), 54);
    check("ld5_no_ack", int'(ctl_io.div_ack), 0);
    wait_ack("ld5", 43, 5);
    measure("d5_p0", 3, 2);
    measure("d5_p1", 3, 2);

    // Table of divisor changes, including loads on a boundary edge
    prev_div = 5;
    for (int r = 0; r < 5; r++) begin
      repeat (tbl[r].load_at) step();
      load(tbl[r].div_in);
      check($sformatf("row%0d_div_hold", r), int'(ctl_io.div_cur), prev_div);
      wait_ack($sformatf("row%0d", r), tbl[r].wait_n, tbl[r].div_in);
      measure($sformatf("row%0d_m", r), tbl[r].lo, tbl[r].hi);
      prev_div = tbl[r].div_in;
    end

    // Rejected divisor
    repeat (3) step();
    load(1);
    check("err_pulse", int'(ctl_io.err_div), 1);
    check("err_div_cur", int'(ctl_io.div_cur), 54);
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i == 0) check("err_one_cycle", int'(ctl_io.err_div), 0);
      if (ctl_io.div_ack) acks++;
    end
    check("err_no_ack", acks, 0);
    check("err_div_cur_after", int'(ctl_io.div_cur), 54);
    measure("err_m", 27, 27);

    // Rejected load leaves pending value intact
    load(9);
    load(1);
    check("pend_err_pulse", int'(ctl_io.err_div), 1);
    wait_ack("pend_keep", 52, 9);
    measure("d9_m", 5, 4);

    // Two loads in one period: last wins, single ack
    load(8);
    step();
    load(6);
    wait_ack("last_wins", 6, 6);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ctl_io.div_ack) acks++;
    end
    check("last_wins_single_ack", acks, 0);
    measure("d6_m", 3, 3);

    // Enable hold at cnt=30
    load(54);
    wait_ack("back54", 5, 54);
    repeat (30) step();
    check("hold_pre_clk", int'(ctl_io.clk_out), 1);
    ctl_io.en = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ctl_io.clk_out !== 1'b1 || ctl_io.tick !== 1'b0) hold_bad++;
    end
    check("hold_stable", hold_bad, 0);
    ctl_io.en = 1'b1;
    n = 0;
    while (!ctl_io.tick && n < 100) begin
      step();
      n++;
    end
    check("hold_resume_tick", n, 23);
    step();
    check("hold_resume_wrap", int'(ctl_io.clk_out), 0);
    measure("hold_m", 27, 27);

    // Apply while stopped
    repeat (30) step();
    ctl_io.en = 1'b0;
    load(4);
    check("stop_ld_clk", int'(ctl_io.clk_out), 1);
    check("stop_ld_no_ack", int'(ctl_io.div_ack), 0);
    step();
    check("stop_apply_ack", int'(ctl_io.div_ack), 1);
    check("stop_apply_div", int'(ctl_io.div_cur), 4);
    check("stop_apply_clk", int'(ctl_io.clk_out), 0);
    ctl_io.en = 1'b1;
    measure("d4_m", 2, 2);

    // Reset mid-period with pending load and a load on the reset edge
    load(54);
    wait_ack("pre_rst", 3, 54);
    repeat (39) step();
    load(10);
    rst = 1'b1;
    ctl_io.div_load = 1'b1;
    ctl_io.div_in   = 16'd5;
    step();
    rst = 1'b0;
    ctl_io.div_load = 1'b0;
    check("mrst_clk", int'(ctl_io.clk_out), 0);
    check("mrst_tick", int'(ctl_io.tick), 0);
    check("mrst_div", int'(ctl_io.div_cur), 54);
    check("mrst_ack", int'(ctl_io.div_ack), 0);
    measure("mrst_m", 27, 27);
    check("mrst_no_apply_ack", int'(ctl_io.div_ack), 0);
    check("mrst_no_apply_div", int'(ctl_io.div_cur), 54);

`ifdef CLKDIV_SYNC_EN
    // Sync forces a period boundary
    repeat (20) step();
    ctl_io.sync_in = 1'b1;
    step();
    ctl_io.sync_in = 1'b0;
    check("sync_clk", int'(ctl_io.clk_out), 0);
    check("sync_tick", int'(ctl_io.tick), 0);
    measure("sync_m", 27, 27);
    // Sync applies a pending divisor
    repeat (20) step();
    load(6);
    ctl_io.sync_in = 1'b1;
    step();
    ctl_io.sync_in = 1'b0;
    check("sync_apply_ack", int'(ctl_io.div_ack), 1);
    check("sync_apply_div", int'(ctl_io.div_cur), 6);
    measure("sync_d6_m", 3, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
